// File: rtl/dkong_input_pkg.sv
// Shared constants for the Donkey Kong cabinet input conditioner.
//   - Channel indices for the board switch bundle feeding IN0/IN1/IN2.
//   - DEF_PULSE_MASK: coin switch in one-shot pulse mode, all others level.
//   - cnt_width(): width of a counter that must hold values 0..n.
package dkong_input_pkg;

  localparam int P1_R    = 0;
  localparam int P1_L    = 1;
  localparam int P1_U    = 2;
  localparam int P1_D    = 3;
  localparam int P1_B1   = 4;
  localparam int P2_R    = 5;
  localparam int P2_L    = 6;
  localparam int P2_U    = 7;
  localparam int P2_D    = 8;
  localparam int P2_B1   = 9;
  localparam int P1_SW   = 10;
  localparam int P2_SW   = 11;
  localparam int COIN_SW = 12;

  localparam int          DEF_NUM_CH     = 16;
  localparam logic [31:0] DEF_PULSE_MASK = 32'(1) << COIN_SW;

  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dkong_input_conditioner_if.sv
// Switch bundle between the board pins and the system input ports.
//   sw_in       raw switch levels (1 = pressed), driven by the board side
//   sw_state    conditioned level per channel
//   press_evt   one-cycle pulse on accepted press
//   release_evt one-cycle pulse on accepted release
//   any_change  OR of all press/release events
// master = pin side (drives sw_in), slave = conditioner.
interface dkong_input_conditioner_if #(
  parameter int NUM_CH = 16
);
  logic [NUM_CH-1:0] sw_in;
  logic [NUM_CH-1:0] sw_state;
  logic [NUM_CH-1:0] press_evt;
  logic [NUM_CH-1:0] release_evt;
  logic              any_change;

  modport master (
    output sw_in,
    input  sw_state, press_evt, release_evt, any_change
  );

  modport slave (
    input  sw_in,
    output sw_state, press_evt, release_evt, any_change
  );
endinterface

// File: rtl/dkong_input_debounce_ch.sv
// One switch channel: two-flop synchroniser, stable-count debounce,
// optional one-shot pulse stretcher, registered press/release events.
//   gclk        clock
//   grst_n      synchronous active-low reset
//   sw_raw      asynchronous raw switch level
//   level       debounced level (level mode) or pulse (pulse mode)
//   press_evt   high in the cycle the accepted level first shows 1
//   release_evt high in the cycle the accepted level first shows 0
module dkong_input_debounce_ch
  import dkong_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int PULSE_CYCLES    = 4096,
  parameter bit PULSE_MODE      = 1'b0,
  parameter bit ENA             = 1'b1
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic sw_raw,
  output logic level,
  output logic press_evt,
  output logic release_evt
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam int PW = cnt_width(PULSE_CYCLES);

  logic          s1, s2, stable, pulse;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pcnt;
  logic          accept;

  // s2 has disagreed with stable for DEBOUNCE_CYCLES consecutive edges
  assign accept = (s2 != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge gclk) begin
    if (!grst_n || !ENA) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      stable      <= 1'b0;
      cnt         <= '0;
      pulse       <= 1'b0;
      pcnt        <= '0;
      press_evt   <= 1'b0;
      release_evt <= 1'b0;
    end else begin
      s1          <= sw_raw;
      s2          <= s1;
      press_evt   <= 1'b0;
      release_evt <= 1'b0;

      if (s2 != stable) begin
        if (accept) begin
          stable <= s2;
          cnt    <= '0;
          // a press landing inside an active pulse is swallowed entirely
          if (s2) press_evt   <= !(PULSE_MODE && pulse);
          else    release_evt <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end

      // pulse ignores releases and re-presses until it has run its length
      if (PULSE_MODE) begin
        if (pulse) begin
          if (pcnt == PW'(PULSE_CYCLES - 1)) pulse <= 1'b0;
          else                               pcnt  <= pcnt + 1'b1;
        end else if (accept && s2) begin
          pulse <= 1'b1;
          pcnt  <= '0;
        end
      end
    end
  end

  assign level = PULSE_MODE ? pulse : stable;

endmodule

// File: rtl/dkong_input_conditioner.sv
// Multi-channel cabinet switch conditioner.
//   masterclk  system clock, rising edge
//   rst_n      synchronous active-low reset
//   bus        dkong_input_conditioner_if.slave (sw_in in; sw_state,
//              press_evt, release_evt, any_change out)
// Per-channel work lives in dkong_input_debounce_ch; this level applies the
// enable mask, output polarity and the any_change reduction.
module dkong_input_conditioner
  import dkong_input_pkg::*;
#(
  parameter int                NUM_CH          = DEF_NUM_CH,
  parameter int                DEBOUNCE_CYCLES = 1024,
  parameter int                PULSE_CYCLES    = 4096,
  parameter logic [NUM_CH-1:0] PULSE_MASK      = '0,
  parameter logic [NUM_CH-1:0] CH_ENA          = '1,
  parameter bit                INVERT_OUT      = 1'b0
) (
  input  logic                       masterclk,
  input  logic                       rst_n,
  dkong_input_conditioner_if.slave   bus
);

  logic [NUM_CH-1:0] level, press, rel;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    dkong_input_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .PULSE_CYCLES    (PULSE_CYCLES),
      .PULSE_MODE      (PULSE_MASK[i]),
      .ENA             (CH_ENA[i])
    ) u_ch (
      .gclk        (masterclk),
      .grst_n      (rst_n),
      .sw_raw      (bus.sw_in[i]),
      .level       (level[i]),
      .press_evt   (press[i]),
      .release_evt (rel[i])
    );
  end

  // disabled channels read as released in whatever polarity is selected
  assign bus.sw_state    = (level & CH_ENA) ^ {NUM_CH{INVERT_OUT}};
  assign bus.press_evt   = press & CH_ENA;
  assign bus.release_evt = rel & CH_ENA;
  assign bus.any_change  = |((press | rel) & CH_ENA);

endmodule
